// File: rtl/strobe_sample_if.sv
// Control/sample bundle between a burst controller and strobe_sample_source.
// master drives the burst controls, slave is the sample source itself.
interface strobe_sample_if #(
    parameter int WIDTH     = 10,
    parameter int DIV_WIDTH = 8
);
    logic                 ena;
    logic                 start;
    logic                 stop;
    logic [1:0]           mode;
    logic [DIV_WIDTH-1:0] period;
    logic [WIDTH-1:0]     count;
    logic [WIDTH-1:0]     data_out;
    logic                 strobe_out;
    logic                 busy;
    logic                 done;

    modport master (
        output ena, start, stop, mode, period, count,
        input  data_out, strobe_out, busy, done
    );

    modport slave (
        input  ena, start, stop, mode, period, count,
        output data_out, strobe_out, busy, done
    );
endinterface

// File: rtl/strobe_sample_source.sv
// Programmable strobed-sample transmitter: ramp / triangle / LFSR / square
// patterns, single-shot or continuous bursts, one strobe per max(period,2) cycles.
module strobe_sample_source #(
    parameter int WIDTH     = 10,
    parameter int DIV_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    strobe_sample_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0]       M_TRI   = 2'b01;
    localparam logic [1:0]       M_LFSR  = 2'b10;
    localparam logic [1:0]       M_SQR   = 2'b11;
    localparam logic [WIDTH-1:0] S_MAX   = '1;
    localparam logic [WIDTH-1:0] S_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] LFSR_SEED = WIDTH'(1);

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [DIV_WIDTH-1:0] ivl_m1_q, ivl_m1_d;
    logic [DIV_WIDTH-1:0] icnt_q, icnt_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     sent_q, sent_d;
    logic [WIDTH-1:0]     pos_q, pos_d;
    logic                 down_q, down_d;
    logic [WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 strobe_q, strobe_d;
    logic                 done_q, done_d;

    // emit-path sources: either the freshly seeded pattern (start) or the live one
    logic                 emit, seed;
    logic [1:0]           src_mode;
    logic [WIDTH-1:0]     src_pos, src_lfsr, src_sent;
    logic                 src_down;

    function automatic logic [WIDTH-1:0] sample_of(input logic [1:0] md,
                                                   input logic [WIDTH-1:0] pos,
                                                   input logic [WIDTH-1:0] lfsr);
        case (md)
            M_LFSR:  return lfsr;
            M_SQR:   return pos[4] ? S_MAX : '0;
            default: return pos;
        endcase
    endfunction

    // Fibonacci x^10 + x^7 + 1, feedback into bit 0
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q);
        return {q[WIDTH-2:0], q[9] ^ q[6]};
    endfunction

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        ivl_m1_d = ivl_m1_q;
        icnt_d   = icnt_q;
        count_d  = count_q;
        sent_d   = sent_q;
        pos_d    = pos_q;
        down_d   = down_q;
        lfsr_d   = lfsr_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        emit     = 1'b0;
        seed     = 1'b0;

        if (bus.ena) begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d  = RUN;
                        mode_d   = bus.mode;
                        ivl_m1_d = (bus.period < DIV_WIDTH'(2)) ? DIV_WIDTH'(1)
                                                                : bus.period - DIV_WIDTH'(1);
                        count_d  = bus.count;
                        icnt_d   = '0;
                        emit     = 1'b1;
                        seed     = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (count_q != '0 && sent_q == count_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (icnt_q == ivl_m1_q) begin
                        icnt_d = '0;
                        emit   = 1'b1;
                    end else begin
                        icnt_d = icnt_q + DIV_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        src_mode = seed ? bus.mode : mode_q;
        src_pos  = seed ? '0 : pos_q;
        src_down = seed ? 1'b0 : down_q;
        src_lfsr = seed ? LFSR_SEED : lfsr_q;
        src_sent = seed ? '0 : sent_q;

        if (emit) begin
            strobe_d = 1'b1;
            data_d   = sample_of(src_mode, src_pos, src_lfsr);
            sent_d   = src_sent + S_ONE;
            lfsr_d   = lfsr_next(src_lfsr);
            down_d   = 1'b0;
            pos_d    = src_pos + S_ONE;
            // triangle bounces at the rails without repeating the peak/trough
            if (src_mode == M_TRI) begin
                if (!src_down) begin
                    down_d = (src_pos == S_MAX);
                    pos_d  = (src_pos == S_MAX) ? src_pos - S_ONE : src_pos + S_ONE;
                end else begin
                    down_d = (src_pos != '0);
                    pos_d  = (src_pos == '0) ? S_ONE : src_pos - S_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            ivl_m1_q <= '0;
            icnt_q   <= '0;
            count_q  <= '0;
            sent_q   <= '0;
            pos_q    <= '0;
            down_q   <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            data_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            ivl_m1_q <= ivl_m1_d;
            icnt_q   <= icnt_d;
            count_q  <= count_d;
            sent_q   <= sent_d;
            pos_q    <= pos_d;
            down_q   <= down_d;
            lfsr_q   <= lfsr_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.strobe_out = strobe_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_strobe_sample_source.sv
// Randomized + directed bench for strobe_sample_source against an index-based
// reference model (sample n computed arithmetically, strobe timing by interval count).
module tb_strobe_sample_source;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    strobe_sample_if #(.WIDTH(10), .DIV_WIDTH(8)) bus ();

    strobe_sample_source #(.WIDTH(10), .DIV_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int lfsr_seq [1023];
    int seen [$];

    bit m_run, m_strobe, m_done;
    int m_mode, m_ivl, m_cnt, m_n, m_since, m_data;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_sample(input int md, input int n);
        int m;
        case (md)
            0: return n % 1024;
            1: begin m = n % 2046; return (m <= 1023) ? m : 2046 - m; end
            2: return lfsr_seq[n % 1023];
            default: return ((n / 16) % 2) ? 1023 : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_strobe = 0; m_done = 0;
        m_n = 0; m_since = 0; m_data = 0;
    endtask

    task automatic model_emit();
        m_data   = exp_sample(m_mode, m_n);
        m_n++;
        m_since  = 0;
        m_strobe = 1;
    endtask

    task automatic model_step();
        m_strobe = 0;
        m_done   = 0;
        if (!bus.ena) return;
        if (!m_run) begin
            if (bus.start && !bus.stop) begin
                m_mode = int'(bus.mode);
                m_ivl  = (bus.period < 2) ? 2 : int'(bus.period);
                m_cnt  = int'(bus.count);
                m_n    = 0;
                m_run  = 1;
                model_emit();
            end
        end else if (bus.stop) begin
            m_run = 0; m_done = 1;
        end else if (m_cnt != 0 && m_n == m_cnt) begin
            m_run = 0; m_done = 1;
        end else begin
            m_since++;
            if (m_since == m_ivl) model_emit();
        end
    endtask

    task automatic compare_all();
        chk("strobe", int'(bus.strobe_out), int'(m_strobe));
        chk("busy",   int'(bus.busy),       int'(m_run));
        chk("done",   int'(bus.done),       int'(m_done));
        chk("data",   int'(bus.data_out),   m_data);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        if (bus.strobe_out) seen.push_back(int'(bus.data_out));
        compare_all();
    endtask

    task automatic start_burst(input int md, input int per, input int cnt);
        bus.mode = 2'(md); bus.period = 8'(per); bus.count = 10'(cnt);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic stop_burst();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        step();
    endtask

    initial begin
        logic [9:0] q;
        int peaks, guard;
        q = 10'h001;
        for (int i = 0; i < 1023; i++) begin
            lfsr_seq[i] = int'(q);
            q = {q[8:0], q[9] ^ q[6]};
        end

        bus.ena = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
        bus.mode = 2'd0; bus.period = 8'd0; bus.count = 10'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 compare_all();
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();

        // ramp, period 2, count 5
        seen.delete();
        start_burst(0, 2, 5);
        repeat (14) step();
        chk("ramp_nstrobe", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk("ramp_val", seen[i], i);

        // triangle, period 4, continuous, 2050 samples
        seen.delete();
        start_burst(1, 4, 0);
        guard = 0;
        while (seen.size() < 2050 && guard < 20000) begin step(); guard++; end
        chk("tri_timeout", int'(guard >= 20000), 0);
        stop_burst();
        peaks = 0;
        foreach (seen[i]) if (seen[i] == 1023) peaks++;
        chk("tri_peaks", peaks, 1);
        if (seen.size() >= 2050) begin
            chk("tri_1023", seen[1023], 1023);
            chk("tri_2046", seen[2046], 0);
            chk("tri_2047", seen[2047], 1);
        end

        // LFSR, period 0, count 3, twice
        for (int r = 0; r < 2; r++) begin
            seen.delete();
            start_burst(2, 0, 3);
            repeat (8) step();
            chk("lfsr_n", seen.size(), 3);
            if (seen.size() == 3) begin
                chk("lfsr_0", seen[0], 'h001);
                chk("lfsr_1", seen[1], 'h002);
                chk("lfsr_2", seen[2], 'h004);
            end
        end

        // square, period 3, stop exactly when a strobe is due after sample 20
        seen.delete();
        start_burst(3, 3, 0);
        guard = 0;
        while (!(m_n == 21 && m_since == m_ivl - 1) && guard < 500) begin step(); guard++; end
        chk("sq_timeout", int'(guard >= 500), 0);
        stop_burst();
        repeat (6) step();
        chk("sq_nstrobe", seen.size(), 21);
        if (seen.size() >= 17) begin
            chk("sq_15", seen[15], 0);
            chk("sq_16", seen[16], 1023);
        end

        // ena low for 5 cycles mid-interval, ramp period 6
        seen.delete();
        start_burst(0, 6, 0);
        repeat (8) step();
        bus.ena = 1'b0;
        repeat (5) step();
        bus.ena = 1'b1;
        repeat (20) step();
        stop_burst();
        foreach (seen[i]) chk("ena_seq", seen[i], i);

        // randomized controls, latched values must be the only ones used
        for (int c = 0; c < 1500; c++) begin
            bus.start  = ($urandom_range(0, 9) == 0);
            bus.stop   = ($urandom_range(0, 39) == 0);
            bus.ena    = ($urandom_range(0, 9) != 0);
            bus.mode   = 2'($urandom_range(0, 3));
            bus.period = 8'($urandom_range(0, 5));
            bus.count  = 10'($urandom_range(0, 6));
            step();
        end
        bus.start = 1'b0; bus.ena = 1'b1;
        stop_burst();

        // async reset mid-burst with start+stop held
        start_burst(0, 3, 0);
        repeat (4) step();
        bus.start = 1'b1; bus.stop = 1'b1;
        @(posedge clk);
        model_step();
        #3 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        repeat (2) step();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 compare_all();
        repeat (10) step();
        bus.start = 1'b0; bus.stop = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/strobe_sample_source.md
# strobe_sample_source

Programmable strobed-sample transmitter; it is the upstream producer for the moving-average filter's strobe/data input. It generates 10-bit samples (ramp, triangle, LFSR noise or square wave) and presents each on `data_out` with a one-cycle `strobe_out` pulse at a programmable interval. Bursts are single-shot or continuous. It replaces hand-driven bench stimulus and serves as an on-chip self-test source.

## Interface

- `WIDTH`, 10: sample width.
- `DIV_WIDTH`, 8: width of the strobe interval field.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  global enable; low freezes all state.
- `start`  in  1  burst start, sampled in IDLE only.
- `stop`  in  1  abort, sampled in RUN only.
- `mode`  in  2  pattern: 00 ramp, 01 triangle, 10 LFSR, 11 square.
- `period`  in  DIV_WIDTH  strobe interval in cycles; values 0–2 all mean 2.
- `count`  in  WIDTH  samples per burst; 0 means continuous.
- `data_out`  out  WIDTH  current sample; held between strobes.
- `strobe_out`  out  1  one-cycle pulse marking a new `data_out`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on return to IDLE.

## Operation

- States: IDLE and RUN.
- Reset values:
  - Outputs `data_out`, `strobe_out`, `busy` and `done` are 0.
  - State is IDLE.
  - LFSR is 10'h001.
  - Interval counter and sample counter are 0.
- IDLE behaviour:
  - `start`=1 and `stop`=0 latches `mode`, `period` and `count`.
  - It reseeds the pattern: ramp, triangle and square to phase 0; LFSR to 10'h001.
  - It enters RUN and emits sample 0 with a strobe on the same edge.
  - `start`=1 and `stop`=1 together: `stop` wins and the block stays in IDLE.
- Mode, period and count are used only as latched; changing the inputs in RUN has no effect.
- RUN, each enabled cycle, in priority order:
  1. `stop`=1: go to IDLE, `done`=1, no strobe.
  2. Previous strobe completed a finite burst (sent == latched count, count ≠ 0): go to IDLE, `done`=1.
  3. Interval counter reaches interval−1: strobe, next sample, sent+1, interval counter cleared.
  4. Otherwise the interval counter increments.
- `start` in RUN is ignored.
- Patterns, sample index n:
  - Ramp: n mod 1024, wraps 1023→0.
  - Triangle: 0,1,…,1023,1022,…,1,0,1,…, with no repeated peak or trough.
  - LFSR: Fibonacci x^10+x^7+1. Output the current state, then shift. feedback = q[9]^q[6], shifted into bit 0. Never all-zero.
  - Square: 16 samples of 0, then 16 samples of 1023, repeating.
- Continuous mode: the sample counter wraps without effect; the burst ends only on `stop`.
- `ena`=0: state, counters, LFSR and `data_out` hold; `strobe_out` and `done` are forced 0; `start` and `stop` are ignored. A strobe due in a disabled cycle is deferred to the next enabled cycle and is not lost.
- `data_out` changes only on strobe edges.

## Timing

- `start` sampled at edge k: `strobe_out`=1 and `busy`=1 in cycle k+1.
- Strobes are spaced exactly max(period,2) enabled cycles apart (rising edge to rising edge). `strobe_out` is never high two cycles in a row.
- Finite burst: `done`=1 in the cycle after the last strobe; `busy` falls in the same cycle.
- `stop` sampled at edge k: `busy`=0 and `done`=1 in cycle k+1. No strobe in cycle k+1, even if one was due.
- Earliest restart: `start` sampled in the `done` cycle; its first strobe follows in the next cycle.
- Asynchronous reset mid-burst: all outputs go to 0 immediately, the block returns to IDLE, and no `done` is emitted.

## Test plan

- Ramp, period=2, count=5, start pulse → 5 strobes in alternate cycles, data 0,1,2,3,4; `done` in the cycle after the 5th strobe; `busy` high across the burst.
- Triangle, period=4, count=0, run 2050 samples → data peaks at 1023 once, returns to 0 at sample 2046, then restarts upward; strobe spacing always 4 cycles.
- LFSR, period=0, count=3 → data 0x001, 0x002, 0x004 at spacing 2; a second start reproduces the identical sequence.
- Square, period=3, count=0, `stop` asserted at the edge where a strobe is due after sample 20 → 16×0 then 1023 from sample 16 onward; no further strobes; one `done` pulse; `busy` low.
- `ena` held low for 5 cycles mid-interval with ramp, period=6 → no strobes while disabled; `data_out` frozen; the next strobe lands after 6 enabled cycles in total; the sequence continues without a skipped value.
- `rst_n` pulsed low mid-burst with `start`+`stop` high together → immediate outputs 0, no `done`; afterwards the block stays in IDLE with no strobes.
